// File: rtl/snake_pixel_renderer.sv
// -----------------------------------------------------------------------------
// snake_pixel_renderer
//
// Purpose:
//   Final video stage of the snake game. Takes the per-pixel entity code and
//   game status from the game-logic stage and produces 12-bit RGB plus VGA
//   syncs. Sync and blank are delayed so they line up with the entity code,
//   which arrives one cycle after the pixel coordinates. Colour and syncs
//   reach the pins exactly two cycles after x_in/y_in. The background is
//   tinted blue when the game is won. It flashes red when the game is over.
//
// Optional feature (macro SNAKE_SCORE_OVERLAY_EN):
//   When this macro is defined, a three-digit decimal score (tail_count) is
//   drawn in white. It uses a scaled 3x5 font in a box at
//   (SCORE_X0, SCORE_Y0). The binary score is converted to BCD once per
//   frame by a sequential double-dabble FSM. When the macro is undefined,
//   the FSM, the font and the box are absent. All other output is identical
//   to the enabled build.
//
// Ports:
//   vga_clk              pixel clock
//   reset                asynchronous, active-low
//   hsync_in, vsync_in   raw syncs, same cycle as x_in/y_in
//   active_in            visible-pixel flag, same cycle as x_in/y_in
//   x_in, y_in           pixel column / row
//   entity               00 head, 01 fruit, 10 tail, 11 empty
//                        (valid one cycle after x_in/y_in)
//   game_over, game_won  game status levels
//   tail_count           score
//   vga_r/g/b            4-bit colour channels
//   vga_hs, vga_vs       syncs aligned to colour
//   frame_tick           registered one-cycle pulse at the end of the frame
// -----------------------------------------------------------------------------
module snake_pixel_renderer #(
  parameter int   V_ACTIVE   = 480,
  parameter int   FLASH_LOG2 = 4,
  parameter int   SCORE_X0   = 8,
  parameter int   SCORE_Y0   = 8,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       active_in,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  input  logic [1:0] entity,
  input  logic       game_over,
  input  logic       game_won,
  input  logic [7:0] tail_count,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_tick
);

  logic        hs1_d, hs1_q, vs1_d, vs1_q, act1_d, act1_q;
  logic        over1_d, over1_q, won1_d, won1_q;
  logic [11:0] rgb_d, rgb_q;
  logic        hs2_d, hs2_q, vs2_d, vs2_q;
  logic        frame_tick_d, frame_tick_q;
  logic [7:0]  frame_cnt_d, frame_cnt_q;
  logic [11:0] bg_colour;
  logic        glyph_pix;

  // Stage 1 delays the raw pixel attributes so they align with the entity code.
  // The frame counter advances one cycle after the registered tick.
  always_comb begin
    hs1_d        = hsync_in;
    vs1_d        = vsync_in;
    act1_d       = active_in;
    over1_d      = game_over;
    won1_d       = game_won;
    frame_tick_d = (y_in == 9'(V_ACTIVE)) && (x_in == 10'd0);
    frame_cnt_d  = frame_cnt_q + {7'd0, frame_tick_q};
  end

  // Stage 2: a won game overrides a lost one.
  // The game-over tint toggles with one bit of the frame counter.
  always_comb begin
    if (won1_q)
      bg_colour = 12'h006;
    else if (over1_q && frame_cnt_q[FLASH_LOG2])
      bg_colour = 12'h400;
    else
      bg_colour = 12'h000;

    if (!act1_q)
      rgb_d = 12'h000;
    else if (glyph_pix)
      rgb_d = 12'hFFF;
    else begin
      case (entity)
        2'b00:   rgb_d = 12'h0F0;
        2'b01:   rgb_d = 12'hF00;
        2'b10:   rgb_d = 12'h080;
        default: rgb_d = bg_colour;
      endcase
    end
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      hs1_q        <= SYNC_IDLE;
      vs1_q        <= SYNC_IDLE;
      act1_q       <= 1'b0;
      over1_q      <= 1'b0;
      won1_q       <= 1'b0;
      rgb_q        <= 12'h000;
      hs2_q        <= SYNC_IDLE;
      vs2_q        <= SYNC_IDLE;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      act1_q       <= act1_d;
      over1_q      <= over1_d;
      won1_q       <= won1_d;
      rgb_q        <= rgb_d;
      hs2_q        <= hs2_d;
      vs2_q        <= vs2_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

`ifdef SNAKE_SCORE_OVERLAY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_COMMIT} bcd_state_t;

  // Each digit is 12 px wide on a 16 px pitch, so the box is 2*16+12 px wide.
  localparam int BOX_W = 44;
  localparam int BOX_H = 20;

  bcd_state_t  state_d, state_q;
  logic [19:0] shreg_d, shreg_q;
  logic [2:0]  shift_cnt_d, shift_cnt_q;
  logic [11:0] digits_d, digits_q;
  logic [9:0]  x1_d, x1_q;
  logic [8:0]  y1_d, y1_q;
  logic [10:0] dx;
  logic [9:0]  dy;
  logic [3:0]  nib;
  logic [14:0] glyph, glyph_sh;

  // Font rows are packed top to bottom, 3 bits each, with the MSB as the leftmost column.
  function automatic logic [14:0] font_rows(input logic [3:0] d);
    case (d)
      4'd0:    return 15'b111_101_101_101_111;
      4'd1:    return 15'b010_110_010_010_111;
      4'd2:    return 15'b111_001_111_100_111;
      4'd3:    return 15'b111_001_111_001_111;
      4'd4:    return 15'b101_101_111_001_001;
      4'd5:    return 15'b111_100_111_001_111;
      4'd6:    return 15'b111_100_111_101_111;
      4'd7:    return 15'b111_001_001_001_001;
      4'd8:    return 15'b111_101_111_101_111;
      4'd9:    return 15'b111_101_111_001_111;
      default: return 15'd0;
    endcase
  endfunction

  // One double-dabble step: correct the BCD nibbles, then shift in the next binary bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    for (int i = 0; i < 3; i++)
      if (a[8+4*i +: 4] >= 4'd5)
        a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  // The BCD conversion starts on the frame tick, so it runs during vblank.
  // Displayed digits change only at COMMIT.
  // A tick that arrives while the FSM is busy is ignored.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    shift_cnt_d = shift_cnt_q;
    digits_d    = digits_q;
    x1_d        = x_in;
    y1_d        = y_in;
    case (state_q)
      ST_IDLE:   if (frame_tick_q) state_d = ST_LOAD;
      ST_LOAD: begin
        shreg_d     = {12'd0, tail_count};
        shift_cnt_d = 3'd0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_d     = dabble_step(shreg_q);
        shift_cnt_d = shift_cnt_q + 3'd1;
        if (shift_cnt_q == 3'd7) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        digits_d = shreg_q[19:8];
        state_d  = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Offsets wrap to large values left of and above the box, so one unsigned compare bounds each axis.
  // The glyph is scaled by 4, so the low two offset bits select nothing.
  always_comb begin
    dx = {1'b0, x1_q} - 11'(SCORE_X0);
    dy = {1'b0, y1_q} - 10'(SCORE_Y0);
    case (dx[5:4])
      2'd0:    nib = digits_q[11:8];
      2'd1:    nib = digits_q[7:4];
      default: nib = digits_q[3:0];
    endcase
    glyph     = font_rows(nib);
    glyph_sh  = glyph << (4'(dy[4:2]) * 4'd3 + 4'(dx[3:2]));
    glyph_pix = (dx < 11'(BOX_W)) && (dy < 10'(BOX_H)) && (dx[3:0] < 4'd12) && glyph_sh[14];
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= 20'd0;
      shift_cnt_q <= 3'd0;
      digits_q    <= 12'd0;
      x1_q        <= 10'd0;
      y1_q        <= 9'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      shift_cnt_q <= shift_cnt_d;
      digits_q    <= digits_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
    end
  end
`else
  logic unused_score_inputs;
  assign unused_score_inputs = ^tail_count;
  assign glyph_pix           = 1'b0;
`endif

  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign vga_hs     = hs2_q;
  assign vga_vs     = vs2_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// -----------------------------------------------------------------------------
// tb_snake_pixel_renderer
//
// Purpose:
//   Self-checking bench for snake_pixel_renderer. Every applied input is
//   recorded per cycle. The expected outputs are derived from that history
//   using plain arithmetic:
//     - colour and syncs appear two cycles after the coordinates;
//     - the frame counter is the number of earlier ticks;
//     - the score shown is the tail_count latched after an accepted tick,
//       visible eleven cycles after the tick.
//   The score-box check is compiled only when SNAKE_SCORE_OVERLAY_EN is defined.
// -----------------------------------------------------------------------------
module tb_snake_pixel_renderer;

  localparam int N        = 8000;
  localparam int SX0      = 8;
  localparam int SY0      = 8;
  localparam int V_ACTIVE = 480;

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       hsync_in = 1'b1, vsync_in = 1'b1, active_in = 1'b0;
  logic [9:0] x_in = '0;
  logic [8:0] y_in = '0;
  logic [1:0] entity = 2'b11;
  logic       game_over = 1'b0, game_won = 1'b0;
  logic [7:0] tail_count = '0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_tick;

  int compared   = 0;
  int mismatched = 0;

  // Per-cycle history since the last reset release, plus derived model state.
  logic [9:0] hx [N];
  logic [8:0] hy [N];
  bit         hhs [N], hvs [N], hact [N], hgo [N], hwon [N], htick [N];
  logic [1:0] hent [N];
  logic [7:0] htc [N], hfc [N], hdig [N];
  int         m;
  bit         pend;
  int         pend_t;
  logic [7:0] pend_val;
  logic [7:0] cur_tc;

  int font_tbl [10][5] = '{'{7,5,5,5,7}, '{2,6,2,2,7}, '{7,1,7,4,7}, '{7,1,7,1,7},
                           '{5,5,7,1,1}, '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1},
                           '{7,5,7,5,7}, '{7,5,7,1,7}};

  snake_pixel_renderer dut (
    .vga_clk(vga_clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .x_in(x_in), .y_in(y_in), .entity(entity),
    .game_over(game_over), .game_won(game_won), .tail_count(tail_count),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_tick(frame_tick)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic bit glyphPixel(input int x, input int y, input int val);
    int dx, dy, w, digit;
    if (x < SX0 || x >= SX0 + 44 || y < SY0 || y >= SY0 + 20) return 1'b0;
    dx = x - SX0;
    dy = y - SY0;
    w  = dx % 16;
    if (w >= 12) return 1'b0;
    case (dx / 16)
      0:       digit = val / 100;
      1:       digit = (val / 10) % 10;
      default: digit = val % 10;
    endcase
    return bit'((font_tbl[digit][dy / 4] >> (2 - w / 4)) & 1);
  endfunction

  function automatic logic [11:0] expRgb(input int k);
    int i, j;
    i = k - 2;
    j = k - 1;
    if (!hact[i]) return 12'h000;
`ifdef SNAKE_SCORE_OVERLAY_EN
    if (glyphPixel(int'(hx[i]), int'(hy[i]), int'(hdig[j]))) return 12'hFFF;
`endif
    case (hent[j])
      2'd0: return 12'h0F0;
      2'd1: return 12'hF00;
      2'd2: return 12'h080;
      default: begin
        if (hwon[i]) return 12'h006;
        if (hgo[i] && ((int'(hfc[j]) / 16) % 2 == 1)) return 12'h400;
        return 12'h000;
      end
    endcase
  endfunction

  task automatic compareField(input string tag, input logic [11:0] got, input logic [11:0] want);
    compared++;
    assert (got === want)
    else begin
      mismatched++;
      $error("[TB] FAIL %s cycle %0d: got %h want %h", tag, m, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y, input bit hs, input bit vs,
                               input bit act, input logic [1:0] ent, input bit go, input bit won,
                               input logic [7:0] tc);
    x_in = x; y_in = y; hsync_in = hs; vsync_in = vs; active_in = act;
    entity = ent; game_over = go; game_won = won; tail_count = tc;
    hx[m] = x; hy[m] = y; hhs[m] = hs; hvs[m] = vs; hact[m] = act;
    hent[m] = ent; hgo[m] = go; hwon[m] = won; htc[m] = tc;
    if (m == 0) begin
      htick[m] = 1'b0;
      hfc[m]   = 8'd0;
      hdig[m]  = 8'd0;
    end else begin
      htick[m] = (int'(hy[m-1]) == V_ACTIVE) && (hx[m-1] == 10'd0);
      hfc[m]   = hfc[m-1] + 8'(htick[m-1]);
      hdig[m]  = hdig[m-1];
    end
    if (pend && m == pend_t + 1) pend_val = htc[m];
    if (pend && m == pend_t + 11) begin
      hdig[m] = pend_val;
      pend    = 1'b0;
    end
    if (htick[m] && !pend) begin
      pend   = 1'b1;
      pend_t = m;
    end
  endtask

  task automatic checkOutput();
    logic [11:0] want_rgb;
    bit want_hs, want_vs;
    if (m < 2) begin
      want_rgb = 12'h000;
      want_hs  = 1'b1;
      want_vs  = 1'b1;
    end else begin
      want_rgb = expRgb(m);
      want_hs  = hhs[m-2];
      want_vs  = hvs[m-2];
    end
    compareField("rgb", {vga_r, vga_g, vga_b}, want_rgb);
    compareField("hs", {11'd0, vga_hs}, {11'd0, want_hs});
    compareField("vs", {11'd0, vga_vs}, {11'd0, want_vs});
    compareField("frame_tick", {11'd0, frame_tick}, {11'd0, htick[m]});
  endtask

  task automatic runCycle(input int x, input int y, input bit hs, input bit vs, input bit act,
                          input int ent, input bit go, input bit won);
    applyStimulus(10'(x), 9'(y), hs, vs, act, 2'(ent), go, won, cur_tc);
    @(negedge vga_clk);
    checkOutput();
    @(posedge vga_clk);
    #1;
    m++;
    if (m >= N) begin
      mismatched++;
      $display("[TB] FAIL history overflow at cycle %0d: got %0d want <%0d", m, m, N);
      $fatal(1, "[TB] history overflow");
    end
  endtask

  task automatic randomCycles(input int n, input int won_pct);
    for (int k = 0; k < n; k++) begin
      int sel, x, y;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        x = 0; y = V_ACTIVE;
      end else if (sel < 5) begin
        x = $urandom_range(0, 63); y = $urandom_range(0, 31);
      end else begin
        x = $urandom_range(0, 799); y = $urandom_range(0, 511);
      end
      if ($urandom_range(0, 99) == 0) cur_tc = 8'($urandom);
      runCycle(x, y, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3),
               bit'($urandom_range(0, 1)), $urandom_range(0, 99) < won_pct);
    end
  endtask

  task automatic checkResetState(input string tag);
    compareField({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    compareField({tag, "_hs"}, {11'd0, vga_hs}, 12'd1);
    compareField({tag, "_vs"}, {11'd0, vga_vs}, 12'd1);
    compareField({tag, "_tick"}, {11'd0, frame_tick}, 12'd0);
  endtask

  task automatic restartModel();
    m    = 0;
    pend = 1'b0;
  endtask

  initial begin
    cur_tc = 8'd42;
    restartModel();
    repeat (3) @(posedge vga_clk);
    #1;
    checkResetState("reset_init");
    reset = 1'b1;

    // Mixed random traffic, including ticks while the FSM is busy.
    randomCycles(800, 12);

    // Fruit outside the score box, then a few other cells.
    runCycle(300, 200, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    runCycle(301, 200, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    runCycle(302, 200, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    runCycle(303, 200, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0);

    // Game over on an empty cell: one tick every 16 cycles, over 40 frames.
    for (int f = 0; f < 40; f++) begin
      runCycle(0, V_ACTIVE, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b0);
      for (int k = 0; k < 15; k++) runCycle(100 + k, 100, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    end

    // A won game overrides game over.
    for (int k = 0; k < 6; k++) runCycle(200 + k, 300, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1);

    // Score 127, then 255.
    // Probe box pixels across the commit window, then scan the whole box.
    for (int s = 0; s < 2; s++) begin
      cur_tc = (s == 0) ? 8'd127 : 8'd255;
      runCycle(0, V_ACTIVE, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) runCycle(SX0 + (k * 7) % 44, SY0 + k % 20, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0);
      for (int y = SY0 - 1; y < SY0 + 21; y++)
        for (int x = SX0 - 2; x < SX0 + 46; x++)
          runCycle(x, y, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    end

    // Blanked pixels are black, even on the head.
    for (int k = 0; k < 4; k++) runCycle(400 + k, 50, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    // Reset asserted mid-line: outputs clear immediately.
    // After release, the first two outputs are black.
    runCycle(500, 120, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    x_in = 10'd501; active_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    reset = 1'b0;
    #1;
    checkResetState("reset_mid");
    repeat (2) @(posedge vga_clk);
    #1;
    checkResetState("reset_hold");
    restartModel();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) runCycle(310 + k, 250, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    randomCycles(300, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
